// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scanner.
// Walks the upstream digit select through the four slots. Each slot opens with a
// dark interval so the upstream digit code can settle. The code is then sampled
// once, decoded and held until the slot ends. Polarity is applied at the output
// registers.
module seg_scan_driver #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int LZB_EN       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] decimal_digit,
    output logic [1:0] select,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_en
);

    localparam int              CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LOAD_AT  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic             POL      = (ACTIVE_LOW != 0);
    localparam logic             LZB      = (LZB_EN != 0);

    // Pin-level values for a dark display.
    localparam logic [6:0] SEG_OFF = {7{POL}};
    localparam logic       DP_OFF  = POL;
    localparam logic [3:0] EN_OFF  = {4{POL}};

    logic [CNT_W-1:0] cnt;
    logic             loaded;

    logic [6:0] seg_p0;
    logic       dp_p0;
    logic [3:0] en_p0;
    logic       vld_p0;
    logic       blank_p0;
    logic [6:0] pattern_p0;

    // Logical segment pattern {g,f,e,d,c,b,a}. Codes 11-15 are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            4'd10:   pat = 7'h39;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Stage p0: decode the upstream code for the current slot.
    // The code is sampled once per slot, on the first enabled edge that takes
    // cnt past the blank interval. After re-enabling, the "loaded" flag allows
    // one reload at a held count beyond that point.
    always_comb begin
        pattern_p0 = seg_decode(decimal_digit);
        blank_p0   = (pattern_p0 == 7'h00) ||
                     (LZB && (select == 2'b11) && (decimal_digit == 4'd0));
        seg_p0     = blank_p0 ? 7'h00 : pattern_p0;
        dp_p0      = !blank_p0 && (select == 2'b10);
        en_p0      = blank_p0 ? 4'b0000 : (4'b0001 << select);
        vld_p0     = !loaded && (cnt >= LOAD_AT) && (cnt != CNT_LAST);
    end

    // Slot counter and digit select. Both freeze while scanning is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            select <= 2'b00;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                cnt    <= '0;
                select <= select + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Stage p1: output registers. They are loaded once per slot and cleared
    // at slot wrap, when disabled, and on reset.
    always_ff @(posedge clk) begin
        if (reset || !enable || (cnt == CNT_LAST)) begin
            loaded   <= 1'b0;
            seg      <= SEG_OFF;
            dp       <= DP_OFF;
            digit_en <= EN_OFF;
        end else if (vld_p0) begin
            loaded   <= 1'b1;
            seg      <= seg_p0 ^ {7{POL}};
            dp       <= dp_p0 ^ POL;
            digit_en <= en_p0 ^ {4{POL}};
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (CLK_DIV=8, BLANK_CYCLES=2, active-low pins).
// Two instances share the same stimulus. One has leading-zero blanking enabled
// and one has it disabled. The upstream digit selector is modelled as a table
// indexed by select.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] decimal_digit;
    logic [1:0] select, select_nl;
    logic [6:0] seg, seg_nl;
    logic       dp, dp_nl;
    logic [3:0] digit_en, digit_en_nl;

    logic [3:0][3:0] codes;   // upstream model: codes[select]

    int tests = 0;
    int fails = 0;

    seg_scan_driver #(.CLK_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1), .LZB_EN(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .decimal_digit(decimal_digit),
        .select(select), .seg(seg), .dp(dp), .digit_en(digit_en)
    );

    seg_scan_driver #(.CLK_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1), .LZB_EN(0)) dut_nl (
        .clk(clk), .reset(reset), .enable(enable), .decimal_digit(decimal_digit),
        .select(select_nl), .seg(seg_nl), .dp(dp_nl), .digit_en(digit_en_nl)
    );

    always #5 clk = ~clk;

    always_comb decimal_digit = codes[select];

    typedef struct {
        string           name;
        logic [3:0][3:0] codes;   // {slot3, slot2, slot1, slot0}
        logic [3:0][6:0] seg;     // expected pin values per slot
        logic [3:0]      dp;
        logic [3:0][3:0] en;
        logic [3:0][6:0] seg_nl;
        logic [3:0][3:0] en_nl;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare both instances. When lit=0, every pin must be inactive.
    task automatic chk_out(input string tag, input logic [1:0] esel, input logic lit,
                           input logic [6:0] es, input logic ed, input logic [3:0] ee,
                           input logic [6:0] esn, input logic [3:0] een);
        logic [6:0] s, sn;
        logic       d;
        logic [3:0] e, en_;
        s = lit ? es : 7'h7F;
        d = lit ? ed : 1'b1;
        e = lit ? ee : 4'hF;
        sn = lit ? esn : 7'h7F;
        en_ = lit ? een : 4'hF;
        chk({tag, " select"},    int'(select),      int'(esel));
        chk({tag, " seg"},       int'(seg),         int'(s));
        chk({tag, " dp"},        int'(dp),          int'(d));
        chk({tag, " digit_en"},  int'(digit_en),    int'(e));
        chk({tag, " nl select"}, int'(select_nl),   int'(esel));
        chk({tag, " nl seg"},    int'(seg_nl),      int'(sn));
        chk({tag, " nl dp"},     int'(dp_nl),       int'(d));
        chk({tag, " nl en"},     int'(digit_en_nl), int'(en_));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        codes  = '0;

        vecs[0] = '{"tied_C", {4'd10, 4'd10, 4'd10, 4'd10},
                    {7'h46, 7'h46, 7'h46, 7'h46}, 4'b1011, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h46, 7'h46, 7'h46, 7'h46}, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[1] = '{"val_47.5", {4'd4, 4'd7, 4'd5, 4'd10},
                    {7'h19, 7'h78, 7'h12, 7'h46}, 4'b1011, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h19, 7'h78, 7'h12, 7'h46}, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[2] = '{"val_07.5", {4'd0, 4'd7, 4'd5, 4'd10},
                    {7'h7F, 7'h78, 7'h12, 7'h46}, 4'b1011, {4'hF, 4'hB, 4'hD, 4'hE},
                    {7'h40, 7'h78, 7'h12, 7'h46}, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[3] = '{"blank_codes", {4'd13, 4'd11, 4'd12, 4'd15},
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111, {4'hF, 4'hF, 4'hF, 4'hF},
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F}, {4'hF, 4'hF, 4'hF, 4'hF}};
        vecs[4] = '{"val_98.0", {4'd9, 4'd8, 4'd0, 4'd10},
                    {7'h10, 7'h00, 7'h40, 7'h46}, 4'b1011, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h10, 7'h00, 7'h40, 7'h46}, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[5] = '{"digits_3216", {4'd3, 4'd2, 4'd1, 4'd6},
                    {7'h30, 7'h24, 7'h79, 7'h02}, 4'b1011, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h30, 7'h24, 7'h79, 7'h02}, {4'h7, 4'hB, 4'hD, 4'hE}};

        // Full 32-cycle scans: after edge k, cnt = k%8 and select = (k/8)%4.
        // The slot is lit once cnt >= 2.
        for (int v = 0; v < 6; v++) begin
            codes = vecs[v].codes;
            enable = 1'b1;
            do_reset();
            chk_out({vecs[v].name, " reset"}, 2'b00, 1'b0, 7'h00, 1'b0, 4'h0, 7'h00, 4'h0);
            for (int k = 1; k <= 32; k++) begin
                int c, s;
                tick();
                c = k % 8;
                s = (k / 8) % 4;
                chk_out($sformatf("%s k=%0d", vecs[v].name, k), 2'(s), (c >= 2),
                        vecs[v].seg[s], vecs[v].dp[s], vecs[v].en[s],
                        vecs[v].seg_nl[s], vecs[v].en_nl[s]);
            end
        end

        // Drop enable at cnt=5 of slot 00 for 10 cycles, then resume with a new code.
        codes = vecs[1].codes;
        do_reset();
        for (int k = 1; k <= 5; k++) tick();
        chk_out("en_drop before", 2'b00, 1'b1, 7'h46, 1'b1, 4'hE, 7'h46, 4'hE);
        enable = 1'b0;
        codes[0] = 4'd5;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_out($sformatf("en_drop off %0d", k), 2'b00, 1'b0, 7'h00, 1'b0, 4'h0, 7'h00, 4'h0);
        end
        enable = 1'b1;
        tick();
        chk_out("en_drop reload cnt6", 2'b00, 1'b1, 7'h12, 1'b1, 4'hE, 7'h12, 4'hE);
        tick();
        chk_out("en_drop cnt7", 2'b00, 1'b1, 7'h12, 1'b1, 4'hE, 7'h12, 4'hE);
        tick();
        chk_out("en_drop wrap", 2'b01, 1'b0, 7'h00, 1'b0, 4'h0, 7'h00, 4'h0);
        tick();
        tick();
        chk_out("en_drop slot01", 2'b01, 1'b1, 7'h12, 1'b1, 4'hD, 7'h12, 4'hD);

        // Reset pulse at cnt=6 of slot 11.
        codes = vecs[1].codes;
        do_reset();
        for (int k = 1; k <= 30; k++) tick();
        chk_out("mid_reset before", 2'b11, 1'b1, 7'h19, 1'b1, 4'h7, 7'h19, 4'h7);
        do_reset();
        chk_out("mid_reset after", 2'b00, 1'b0, 7'h00, 1'b0, 4'h0, 7'h00, 4'h0);
        tick();
        chk_out("mid_reset cnt1", 2'b00, 1'b0, 7'h00, 1'b0, 4'h0, 7'h00, 4'h0);
        tick();
        chk_out("mid_reset cnt2", 2'b00, 1'b1, 7'h46, 1'b1, 4'hE, 7'h46, 4'hE);

        // Blank code 12 in slot 01, then change it mid-slot. A lit digit is also
        // changed mid-slot in slot 10.
        codes = {4'd4, 4'd7, 4'd12, 4'd10};
        do_reset();
        for (int k = 1; k <= 8; k++) tick();
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk_out($sformatf("code12 cnt%0d", c), 2'b01, 1'b0, 7'h00, 1'b0, 4'h0, 7'h00, 4'h0);
        end
        codes[1] = 4'd5;
        for (int c = 5; c <= 7; c++) begin
            tick();
            chk_out($sformatf("code12 late cnt%0d", c), 2'b01, 1'b0, 7'h00, 1'b0, 4'h0, 7'h00, 4'h0);
        end
        tick();
        chk_out("code12 wrap", 2'b10, 1'b0, 7'h00, 1'b0, 4'h0, 7'h00, 4'h0);
        tick();
        tick();
        tick();
        tick();
        chk_out("hold cnt4", 2'b10, 1'b1, 7'h78, 1'b0, 4'hB, 7'h78, 4'hB);
        codes[2] = 4'd8;
        for (int c = 5; c <= 7; c++) begin
            tick();
            chk_out($sformatf("hold cnt%0d", c), 2'b10, 1'b1, 7'h78, 1'b0, 4'hB, 7'h78, 4'hB);
        end
        tick();
        chk_out("hold wrap", 2'b11, 1'b0, 7'h00, 1'b0, 4'h0, 7'h00, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
